euclidean_distance_compare: RTL and testbench

- Streaming nearest-template matcher for the speech-recognition datapath.
- Distance stage: accumulates squared differences between two sample streams into a running squared Euclidean distance, tagging each result with a word index.
- Comparator stage: tracks the smallest distance seen and the word index that produced it.
- Sits between the feature extractor/template ROM and the recognition result register.

---
 rtl/euclidean_distance_compare_if.sv | 26 ++
 rtl/euclidean_distance_compare.sv | 53 +++++
 tb/tb_euclidean_distance_compare.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/euclidean_distance_compare_if.sv
// Sample-pair stream into the nearest-template matcher and its distance/best-match results.
interface euclidean_distance_compare_if #(
  parameter int DATA_W = 16,
  parameter int WORD_W = 4,
  parameter int ACC_W  = 64
);
  logic [DATA_W-1:0] idata_0;
  logic [DATA_W-1:0] idata_1;
  logic [WORD_W-1:0] iword;
  logic              ivalid;
  logic              ovalid;
  logic [WORD_W-1:0] oword;
  logic [ACC_W-1:0]  odata;
  logic [WORD_W-1:0] obest_word;
  logic [ACC_W-1:0]  obest_dist;

  modport master (
    output idata_0, idata_1, iword, ivalid,
    input  ovalid, oword, odata, obest_word, obest_dist
  );

  modport slave (
    input  idata_0, idata_1, iword, ivalid,
    output ovalid, oword, odata, obest_word, obest_dist
  );
endinterface

// File: rtl/euclidean_distance_compare.sv
// Running squared Euclidean distance (1 cycle) feeding a min-distance tracker (+1 cycle); no backpressure.
// EUCLID_ACC_SATURATE_EN: accumulator clamps at all-ones instead of wrapping.
module euclidean_distance_compare #(
  parameter int DATA_W = 16,
  parameter int WORD_W = 4,
  parameter int ACC_W  = 64
) (
  input logic iclk,
  input logic irstn,
  euclidean_distance_compare_if.slave bus
);
  localparam int SQ_W = 2 * DATA_W;

  logic [DATA_W-1:0] diff;
  logic [SQ_W-1:0]   sq;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_next;

  always_comb begin
    diff = (bus.idata_0 >= bus.idata_1) ? (bus.idata_0 - bus.idata_1)
                                        : (bus.idata_1 - bus.idata_0);
    sq   = SQ_W'(diff) * SQ_W'(diff);
    sum  = {1'b0, bus.odata} + (ACC_W+1)'(sq);
`ifdef EUCLID_ACC_SATURATE_EN
    acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
  end

  always_ff @(posedge iclk) begin
    if (!irstn) begin
      bus.odata      <= '0;
      bus.ovalid     <= 1'b0;
      bus.oword      <= '0;
      bus.obest_dist <= '1;
      bus.obest_word <= '0;
    end else begin
      if (bus.ivalid) begin
        bus.odata  <= acc_next;
        bus.oword  <= bus.iword;
        bus.ovalid <= 1'b1;
      end else begin
        bus.ovalid <= 1'b0;
      end
      // Strict compare so a tie leaves the earlier word in place.
      if (bus.ovalid && (bus.odata < bus.obest_dist)) begin
        bus.obest_dist <= bus.odata;
        bus.obest_word <= bus.oword;
      end
    end
  end
endmodule

// File: tb/tb_euclidean_distance_compare.sv
// Directed bench: main 64-bit instance plus a 33-bit instance that can reach overflow in a few pairs.
module tb_euclidean_distance_compare;
  logic iclk = 1'b0;
  logic irstn;
  int   checks = 0;
  int   passes = 0;

  euclidean_distance_compare_if #(.DATA_W(16), .WORD_W(4), .ACC_W(64)) bus_a ();
  euclidean_distance_compare_if #(.DATA_W(16), .WORD_W(4), .ACC_W(33)) bus_b ();

  euclidean_distance_compare #(.DATA_W(16), .WORD_W(4), .ACC_W(64)) dut_a (
    .iclk (iclk),
    .irstn(irstn),
    .bus  (bus_a)
  );

  euclidean_distance_compare #(.DATA_W(16), .WORD_W(4), .ACC_W(33)) dut_b (
    .iclk (iclk),
    .irstn(irstn),
    .bus  (bus_b)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step_a(input int a, input int b, input int w, input logic v);
    bus_a.idata_0 = 16'(a);
    bus_a.idata_1 = 16'(b);
    bus_a.iword   = 4'(w);
    bus_a.ivalid  = v;
    @(posedge iclk);
    #1;
  endtask

  task automatic step_b(input int a, input int b, input int w, input logic v);
    bus_b.idata_0 = 16'(a);
    bus_b.idata_1 = 16'(b);
    bus_b.iword   = 4'(w);
    bus_b.ivalid  = v;
    @(posedge iclk);
    #1;
  endtask

  localparam logic [63:0] ONES64 = '1;
  localparam logic [63:0] S1     = 64'd4294836225;   // 65535^2

  initial begin
    bus_b.idata_0 = '0; bus_b.idata_1 = '0; bus_b.iword = '0; bus_b.ivalid = 1'b0;

    // Reset state
    irstn = 1'b0;
    step_a(0, 0, 0, 1'b0);
    check("rst_odata", bus_a.odata, 0);
    check("rst_ovalid", 64'(bus_a.ovalid), 0);
    check("rst_oword", 64'(bus_a.oword), 0);
    check("rst_best_dist", bus_a.obest_dist, ONES64);
    check("rst_best_word", 64'(bus_a.obest_word), 0);
    irstn = 1'b1;

    // Basic accumulation, diff 2 each pair; last pair is swapped order
    for (int i = 0; i < 9; i++) begin
      if (i < 8) step_a(16 - 2*i, 14 - 2*i, i + 1, 1'b1);
      else       step_a(1, 3, i + 1, 1'b1);
      check("basic_odata", bus_a.odata, 64'(4 * (i + 1)));
      check("basic_ovalid", 64'(bus_a.ovalid), 1);
      check("basic_oword", 64'(bus_a.oword), 64'(i + 1));
      if (i == 2) begin
        check("basic_best_dist", bus_a.obest_dist, 4);
        check("basic_best_word", 64'(bus_a.obest_word), 1);
      end
    end

    // Gap holds data, drops valid
    step_a(0, 0, 0, 1'b0);
    check("gap_ovalid", 64'(bus_a.ovalid), 0);
    check("gap_odata", bus_a.odata, 36);
    check("gap_oword", 64'(bus_a.oword), 9);

    // Sync reset mid-stream, reset wins over ivalid
    irstn = 1'b0;
    step_a(100, 0, 7, 1'b1);
    check("srst_odata", bus_a.odata, 0);
    check("srst_ovalid", 64'(bus_a.ovalid), 0);
    check("srst_best_dist", bus_a.obest_dist, ONES64);
    irstn = 1'b1;
    step_a(0, 0, 0, 1'b0);
    check("post_rst_ovalid", 64'(bus_a.ovalid), 0);
    check("post_rst_odata", bus_a.odata, 0);

    // Restart, diff 3 each pair
    for (int i = 0; i < 9; i++) begin
      step_a(63 - 3*i, 60 - 3*i, 2 + i, 1'b1);
      check("restart_odata", bus_a.odata, 64'(9 * (i + 1)));
    end
    step_a(10, 13, 11, 1'b1);
    check("swap_odata", bus_a.odata, 90);
    step_a(0, 0, 0, 1'b0);
    check("restart_best_dist", bus_a.obest_dist, 9);
    check("restart_best_word", 64'(bus_a.obest_word), 2);

    // Comparator tie: 49 (word 3) then 49 (word 5) keeps word 3
    irstn = 1'b0;
    step_a(0, 0, 0, 1'b0);
    irstn = 1'b1;
    step_a(7, 0, 3, 1'b1);
    step_a(5, 5, 5, 1'b1);
    check("tie_odata", bus_a.odata, 49);
    check("tie_oword", 64'(bus_a.oword), 5);
    step_a(0, 0, 0, 1'b0);
    step_a(0, 0, 0, 1'b0);
    check("tie_best_dist", bus_a.obest_dist, 49);
    check("tie_best_word", 64'(bus_a.obest_word), 3);

    // Overflow on 33-bit accumulator
    step_b(65535, 0, 1, 1'b1);
    check("ovf_odata1", bus_b.odata, S1);
    step_b(0, 65535, 2, 1'b1);
    check("ovf_odata2", bus_b.odata, 2 * S1);
    check("ovf_best1", bus_b.obest_dist, S1);
    step_b(65535, 0, 3, 1'b1);
`ifdef EUCLID_ACC_SATURATE_EN
    check("ovf_odata3_sat", bus_b.odata, 64'h1_FFFF_FFFF);
`else
    check("ovf_odata3_wrap", bus_b.odata, 64'd4294574083);
`endif
    step_b(0, 0, 0, 1'b0);
`ifdef EUCLID_ACC_SATURATE_EN
    check("ovf_best_sat", bus_b.obest_dist, S1);
    check("ovf_word_sat", 64'(bus_b.obest_word), 1);
`else
    check("ovf_best_wrap", bus_b.obest_dist, 64'd4294574083);
    check("ovf_word_wrap", 64'(bus_b.obest_word), 3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
